// File: rtl/sb_ccff_pkg.sv
// Shared types and default sizing for the switch-block configuration-chain programmer.
package sb_ccff_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 128;
  localparam int unsigned DEF_WORD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sb_ccff_readback_capture.sv
// Deserializes the chain tail into WORD_W words, LSB first; a short final word is zero-padded.
// Only instantiated when SB_CCFF_READBACK_EN is defined.
module sb_ccff_readback_capture #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              capture_en,
  input  logic              last_bit,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] cap_q;
  logic [WORD_W-1:0] cap_d;

  always_comb begin
    cap_d        = cap_q;
    cap_d[idx_q] = ccff_tail;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      idx_q    <= '0;
      cap_q    <= '0;
      rb_word  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        idx_q <= '0;
        cap_q <= '0;
      end else if (capture_en) begin
        // Clearing cap_q on emit is what zero-pads a short final word.
        if (idx_q == LAST_IDX || last_bit) begin
          rb_word  <= cap_d;
          rb_valid <= 1'b1;
          cap_q    <= '0;
          idx_q    <= '0;
        end else begin
          cap_q <= cap_d;
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sb_ccff_programmer.sv
// Streams bitstream words LSB first into a CHAIN_LEN-bit configuration flip-flop chain.
// Optional tail readback is built when SB_CCFF_READBACK_EN is defined.
module sb_ccff_programmer
  import sb_ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WCNT_W-1:0]  word_cnt_q;
  logic [WORD_W-1:0]  shift_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (cfg_valid) state_d = ST_SHIFT;
      ST_SHIFT: begin
        // Chain end wins over word end, dropping the unused tail of a short final word.
        if (bit_cnt_q == LAST_BIT)       state_d = ST_DONE;
        else if (word_cnt_q == LAST_WBIT) state_d = ST_LOAD;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: if (start) bit_cnt_q <= '0;
        ST_LOAD: if (cfg_valid) begin
          shift_q    <= cfg_word;
          word_cnt_q <= '0;
        end
        ST_SHIFT: begin
          shift_q    <= shift_q >> 1;
          bit_cnt_q  <= bit_cnt_q + 1'b1;
          word_cnt_q <= word_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are masked by pReset so they read zero for the whole reset window.
  assign cfg_ready = (state_q == ST_LOAD) & ~pReset;
  assign prog_en   = (state_q == ST_SHIFT) & ~pReset;
  assign ccff_head = prog_en & shift_q[0];
  assign busy      = ((state_q == ST_LOAD) | (state_q == ST_SHIFT)) & ~pReset;
  assign done      = (state_q == ST_DONE) & ~pReset;

`ifdef SB_CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_word_q;
  logic              rb_valid_q;

  sb_ccff_readback_capture #(
    .WORD_W(WORD_W)
  ) u_readback_capture (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .clear     (state_q == ST_IDLE),
    .capture_en(prog_en),
    .last_bit  (prog_en && (bit_cnt_q == LAST_BIT)),
    .ccff_tail (ccff_tail),
    .rb_word   (rb_word_q),
    .rb_valid  (rb_valid_q)
  );

  assign rb_word  = pReset ? '0 : rb_word_q;
  assign rb_valid = rb_valid_q & ~pReset;
`else
  logic unused_ccff_tail;
  assign unused_ccff_tail = ccff_tail;
  assign rb_word          = '0;
  assign rb_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_sb_ccff_programmer.sv
// Scoreboard bench: directed programming runs on a 16-bit and a 12-bit chain, with model chains on the tails.
module tb_sb_ccff_programmer;

  logic       prog_clk = 1'b0;
  logic       pReset, start, abort, cfg_valid;
  logic [7:0] cfg_word;
  logic       chain_load;
  logic       sel;

  logic       a_ready, a_head, a_en, a_tail, a_busy, a_done, a_rbv;
  logic [7:0] a_rbw;
  logic       b_ready, b_head, b_en, b_tail, b_busy, b_done, b_rbv;
  logic [7:0] b_rbw;
  logic [15:0] a_chain;
  logic [11:0] b_chain;

  logic       s_ready, s_head, s_en, s_busy, s_done, s_rbv;
  logic [7:0] s_rbw;

  bit         head_q[$];
  logic [7:0] rb_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, en_cnt = 0, done_cnt = 0, load_entries = 0;
  int last_en_cyc = 0, done_cyc = 0;
  logic prev_rd = 1'b0;

  always #5 prog_clk = ~prog_clk;

  sb_ccff_programmer #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .ccff_head(a_head), .prog_en(a_en), .ccff_tail(a_tail), .busy(a_busy),
    .done(a_done), .rb_word(a_rbw), .rb_valid(a_rbv));

  sb_ccff_programmer #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .ccff_head(b_head), .prog_en(b_en), .ccff_tail(b_tail), .busy(b_busy),
    .done(b_done), .rb_word(b_rbw), .rb_valid(b_rbv));

  // Model chains: head enters at the top, tail is bit 0.
  assign a_tail = a_chain[0];
  assign b_tail = b_chain[0];
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (chain_load) begin
      a_chain <= 16'h1234;
      b_chain <= 12'hABC;
    end else begin
      if (a_en) a_chain <= {a_head, a_chain[15:1]};
      if (b_en) b_chain <= {b_head, b_chain[11:1]};
    end
  end

  always_comb begin
    if (sel) begin
      s_ready = b_ready; s_head = b_head; s_en = b_en; s_busy = b_busy;
      s_done = b_done; s_rbv = b_rbv; s_rbw = b_rbw;
    end else begin
      s_ready = a_ready; s_head = a_head; s_en = a_en; s_busy = a_busy;
      s_done = a_done; s_rbv = a_rbv; s_rbw = a_rbw;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the selected DUT shifts or presents readback.
  always @(negedge prog_clk) begin
    if (s_en) begin
      en_cnt++;
      last_en_cyc = cyc;
      if (head_q.size() == 0) check("head_unexpected", 1, 0);
      else check("ccff_head", s_head, head_q.pop_front());
    end
    if (s_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_rbv) begin
      if (rb_q.size() == 0) check("rb_unexpected", 1, 0);
      else check("rb_word", s_rbw, rb_q.pop_front());
    end
    if (s_ready && !prev_rd) load_entries++;
    prev_rd = s_ready;
  end

  task automatic push_word(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) head_q.push_back(w[i]);
  endtask

  task automatic reload();
    @(negedge prog_clk); chain_load = 1'b1;
    @(negedge prog_clk); chain_load = 1'b0;
  endtask

  task automatic do_start();
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int stall);
    int t = 0;
    while (!s_ready && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    if (!s_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge prog_clk);
      check("stall_prog_en", s_en, 0);
      check("stall_busy", s_busy, 1);
    end
    cfg_valid = 1'b1;
    cfg_word  = w;
    @(negedge prog_clk);
    cfg_valid = 1'b0;
    cfg_word  = '0;
    if (stall > 0) check("resume_prog_en", s_en, 1);
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (done_cnt == base && t < 100) begin
      @(negedge prog_clk); #1;
      t++;
    end
    repeat (3) @(negedge prog_clk);
    #1;
    check("done_pulse_count", done_cnt - base, 1);
  endtask

  task automatic run_prog(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                          input int exp_bits);
    int base_en, base_done, base_load;
    #1;
    base_en = en_cnt; base_done = done_cnt; base_load = load_entries;
    do_start();
    send_word(w0, stall);
    send_word(w1, 0);
    wait_done(base_done);
    check("prog_en_count", en_cnt - base_en, exp_bits);
    check("done_after_last_bit", done_cyc - last_en_cyc, 1);
    check("load_entries", load_entries - base_load, 2);
    check("head_q_empty", head_q.size(), 0);
    check("rb_q_empty", rb_q.size(), 0);
    check("busy_after_done", s_busy, 0);
  endtask

  task automatic expect_a5_3c();
    push_word(8'hA5, 8);
    push_word(8'h3C, 8);
`ifdef SB_CCFF_READBACK_EN
    rb_q.push_back(8'h34);
    rb_q.push_back(8'h12);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base_en, base_done;
    sel = 1'b0; pReset = 1'b1; start = 1'b1; abort = 1'b0;
    cfg_valid = 1'b0; cfg_word = '0; chain_load = 1'b1;

    // Reset state, with start held high and ignored.
    repeat (3) @(negedge prog_clk);
    check("rst_cfg_ready", a_ready, 0);
    check("rst_ccff_head", a_head, 0);
    check("rst_prog_en", a_en, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rb_word", a_rbw, 0);
    check("rst_rb_valid", a_rbv, 0);
    check("rst_b_busy", b_busy, 0);
    pReset = 1'b0; start = 1'b0; chain_load = 1'b0;
    @(negedge prog_clk);
    check("idle_after_rst_busy", a_busy, 0);

    // Two-word program into a 16-bit chain.
    reload();
    expect_a5_3c();
    run_prog(8'hA5, 8'h3C, 0, 16);

    // Producer stalls five cycles in LOAD before the first word.
    reload();
    expect_a5_3c();
    run_prog(8'hA5, 8'h3C, 5, 16);

    // Abort mid-word, then a clean rerun.
    reload();
    push_word(8'hA5, 4);
    #1; base_en = en_cnt; base_done = done_cnt;
    do_start();
    send_word(8'hA5, 0);
    repeat (3) @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort_prog_en", a_en, 0);
    check("abort_busy", a_busy, 0);
    check("abort_cfg_ready", a_ready, 0);
    repeat (5) @(negedge prog_clk);
    #1;
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_bits", en_cnt - base_en, 4);
    check("abort_head_q_empty", head_q.size(), 0);
    reload();
    expect_a5_3c();
    run_prog(8'hA5, 8'h3C, 0, 16);

    // Reset mid-shift, start held during reset.
    reload();
    push_word(8'hA5, 2);
    do_start();
    send_word(8'hA5, 0);
    @(negedge prog_clk); #1;
    pReset = 1'b1; start = 1'b1;
    @(negedge prog_clk);
    check("midrst_cfg_ready", a_ready, 0);
    check("midrst_ccff_head", a_head, 0);
    check("midrst_prog_en", a_en, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    check("midrst_rb_valid", a_rbv, 0);
    repeat (2) @(negedge prog_clk);
    check("midrst_start_ignored", a_busy, 0);
    pReset = 1'b0; start = 1'b0;
    @(negedge prog_clk);
    check("postrst_idle", a_busy, 0);
    check("midrst_head_q_empty", head_q.size(), 0);

    // 12-bit chain: second word is truncated to four bits.
    sel = 1'b1;
    reload();
    for (int i = 0; i < 12; i++) head_q.push_back(1'b1);
`ifdef SB_CCFF_READBACK_EN
    rb_q.push_back(8'hBC);
    rb_q.push_back(8'h0A);
`endif
    run_prog(8'hFF, 8'h0F, 0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
